// File: rtl/mem_blk_ctrl_if.sv
// mem_blk_ctrl_if: block request/response bus between a cache refill port
// and the block memory controller.
//   master (requester): drives addr, rd_en, wr_en, wr_data;
//                       sees rd_data, rd_valid, wr_done, busy (and err).
//   slave  (memory)   : the mirror image.
// Optional macro MEM_BLK_ERR_EN adds the err response bit.
interface mem_blk_ctrl_if #(
    parameter int PA_WIDTH  = 32,
    parameter int MEM_WIDTH = 128
);
    logic [PA_WIDTH-1:0]  addr;
    logic                 rd_en;
    logic                 wr_en;
    logic [MEM_WIDTH-1:0] wr_data;
    logic [MEM_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 wr_done;
    logic                 busy;
`ifdef MEM_BLK_ERR_EN
    logic                 err;

    modport master (output addr, rd_en, wr_en, wr_data,
                    input  rd_data, rd_valid, wr_done, busy, err);
    modport slave  (input  addr, rd_en, wr_en, wr_data,
                    output rd_data, rd_valid, wr_done, busy, err);
`else
    modport master (output addr, rd_en, wr_en, wr_data,
                    input  rd_data, rd_valid, wr_done, busy);
    modport slave  (input  addr, rd_en, wr_en, wr_data,
                    output rd_data, rd_valid, wr_done, busy);
`endif
endinterface

// File: rtl/mem_blk_ctrl.sv
// mem_blk_ctrl: block-granular main memory with fixed read/write latency.
// One block transaction in flight at a time; completion is reported with a
// single-cycle rd_valid / wr_done pulse, busy covers the waiting period.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (storage array is not cleared)
//   bus  - mem_blk_ctrl_if.slave (addr, rd_en, wr_en, wr_data ->
//          rd_data, rd_valid, wr_done, busy [, err])
// Optional macro MEM_BLK_ERR_EN: adds err, pulsed with the response for
// out-of-range addresses or simultaneous rd_en/wr_en. Out-of-range reads
// return zero, out-of-range writes are dropped. Without it, upper address
// bits alias and simultaneous requests silently become writes.
module mem_blk_ctrl #(
    parameter int PA_WIDTH   = 32,
    parameter int MEM_WIDTH  = 128,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_blk_ctrl_if.slave  bus
);
    localparam int BLK_OFF = $clog2(MEM_WIDTH / 8);
    localparam int IDX_HI  = BLK_OFF + DEPTH_LOG2;
    // Counter is loaded with LAT-1 so the response lands on edge E0+LAT.
    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [MEM_WIDTH-1:0]  data_q;
    logic [MEM_WIDTH-1:0]  rd_data_q;
    logic                  rd_valid_q;
    logic                  wr_done_q;
    logic                  busy_q;
    logic                  commit;

    logic [MEM_WIDTH-1:0]  mem [2**DEPTH_LOG2];

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.busy     = busy_q;

`ifdef MEM_BLK_ERR_EN
    logic oor_q;
    logic both_q;
    logic err_q;
    logic unused_off_bits;

    assign bus.err         = err_q;
    assign commit          = (state == WR_WAIT) && (cnt == 4'd0) && !oor_q;
    assign unused_off_bits = ^bus.addr[BLK_OFF-1:0];
`else
    logic unused_addr_bits;

    assign commit           = (state == WR_WAIT) && (cnt == 4'd0);
    assign unused_addr_bits = ^{bus.addr[PA_WIDTH-1:IDX_HI], bus.addr[BLK_OFF-1:0]};
`endif

    // Storage has no reset. An asynchronous reset forces state to IDLE
    // before the next edge, so an aborted write can never commit.
    always_ff @(posedge clk) begin
        if (commit)
            mem[idx_q] <= data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            idx_q      <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef MEM_BLK_ERR_EN
            oor_q      <= 1'b0;
            both_q     <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
`ifdef MEM_BLK_ERR_EN
            err_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.rd_en || bus.wr_en) begin
                        idx_q  <= bus.addr[IDX_HI-1:BLK_OFF];
                        data_q <= bus.wr_data;
                        busy_q <= 1'b1;
`ifdef MEM_BLK_ERR_EN
                        oor_q  <= |bus.addr[PA_WIDTH-1:IDX_HI];
                        both_q <= bus.rd_en && bus.wr_en;
`endif
                        // Write wins when both are requested.
                        if (bus.wr_en) begin
                            cnt   <= WR_CNT;
                            state <= WR_WAIT;
                        end else begin
                            cnt   <= RD_CNT;
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
`ifdef MEM_BLK_ERR_EN
                        rd_data_q <= oor_q ? '0 : mem[idx_q];
                        err_q     <= oor_q || both_q;
`else
                        rd_data_q <= mem[idx_q];
`endif
                        rd_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == 4'd0) begin
`ifdef MEM_BLK_ERR_EN
                        err_q <= oor_q || both_q;
`endif
                        wr_done_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_blk_ctrl.md
Name: mem_blk_ctrl

Overview:
- Block-granular main-memory model with controller; the cache's refill/write-back port talks to it directly.
- Accepts one block read or block write at a time and enforces fixed, parameterised read and write latencies.
- Reports completion with single-cycle pulses (rd_valid, wr_done); holds busy while a transaction is in flight.
- Replaces the zero-latency memory stand-in so that cache miss handling is exercised with realistic stalls.

Parameters:
- PA_WIDTH, 32, physical address width.
- MEM_WIDTH, 128, block width in bits; must be a multiple of 8; block offset width BLK_OFF = log2(MEM_WIDTH/8) = 4.
- DEPTH_LOG2, 10, log2 of number of blocks stored (1024).
- RD_LAT, 4, read latency in clock edges; legal range 1..15.
- WR_LAT, 4, write latency in clock edges; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- addr  input  PA_WIDTH  byte address of block; offset bits ignored.
- rd_en  input  1  block read request.
- wr_en  input  1  block write request.
- wr_data  input  MEM_WIDTH  block to write.
- rd_data  output  MEM_WIDTH  block read data; registered.
- rd_valid  output  1  one-cycle pulse; rd_data valid.
- wr_done  output  1  one-cycle pulse; write committed.
- busy  output  1  transaction in flight; requests ignored.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, wr_done=0, busy=0, err=0, FSM=IDLE, counter=0.
- Reset does not clear the storage array.
- Index = addr[BLK_OFF+DEPTH_LOG2-1:BLK_OFF].
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE: when rd_en|wr_en is sampled at edge E0:
  - Latch addr index and wr_data; set busy=1.
  - Load counter with LAT-1 and go to RD_WAIT or WR_WAIT.
  - If rd_en and wr_en are both high, the write wins.
- RD_WAIT: counter decrements each edge. On the edge where counter==0 (edge E0+RD_LAT):
  - rd_data <= mem[idx]; rd_valid=1 for one cycle.
  - busy=0; return to IDLE.
- WR_WAIT: same counting. At edge E0+WR_LAT:
  - mem[idx] <= latched data; wr_done=1 for one cycle.
  - busy=0; return to IDLE.
- Requests are sampled only in IDLE with busy=0. rd_en/wr_en while busy are ignored, not queued; the requester holds the request until the response pulse.
- A request present in the response cycle (busy=0) is accepted at the next edge: back-to-back throughput is one transaction per LAT+1 cycles.
- rd_data holds its last value between reads; it is unaffected by writes.
- Read-after-write to the same index returns the new data (the write is committed before the read is accepted).
- Latency 1: response pulse in the cycle immediately after acceptance.
- Reset asserted mid-transaction:
  - Aborts immediately; outputs go to reset values.
  - A pending write is not committed; a pending read produces no rd_valid.
- Latched addr/data are unaffected by input changes after acceptance.

Optional Feature:
- Macro MEM_BLK_ERR_EN.
- Defined: adds output err (1 bit), registered, reset 0. err pulses one cycle, concurrent with the response, when:
  - addr bits above BLK_OFF+DEPTH_LOG2 are nonzero (out-of-range); or
  - rd_en&wr_en were both high at acceptance.
- Out-of-range read returns rd_data=0 with rd_valid. Out-of-range write is dropped but still pulses wr_done.
- Not defined: no err port; upper address bits ignored (aliasing); simultaneous requests resolve as write-priority silently.

Test Plan:
- Reset then idle:
  - rst pulse -> all outputs 0, busy=0.
- Write then read, default parameters:
  - Write wr_data=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 to addr=32'h40 (index 4) -> busy high 4 cycles, wr_done pulse at edge 4.
  - Then read addr=32'h4C (same index) -> rd_valid at edge 4 after accept, rd_data equals the written value.
- Busy rejection:
  - During a read of index 4, pulse wr_en to addr 32'h80 -> ignored; mem[8] unchanged on a later read; no extra wr_done.
- Simultaneous request:
  - rd_en=wr_en=1, addr=32'h100, data=128'hFF -> write performed, wr_done only.
  - With MEM_BLK_ERR_EN: err=1 with wr_done.
- Reset mid-write:
  - Accept write to index 2 with data 128'hAA, assert rst at counter=1 -> no wr_done; later read of index 2 returns the prior contents.
- Latency sweep:
  - RD_LAT=1, WR_LAT=7 -> rd_valid 1 edge after accept, wr_done 7 edges after accept.
  - Back-to-back reads spaced LAT+1 cycles.
